// File: rtl/code_writer_if.sv
// Handshake/bus bundle between the digit source and the password writer.
interface code_writer_if #(parameter int unsigned DW = 8);
  logic          chg_req;
  logic          abort;
  logic          din_vld;
  logic [1:0]    din;
  logic [DW-1:0] code;
  logic          busy;
  logic [1:0]    stage;
  logic [3:0]    cnt;
  logic          done;
  logic          err;
  logic          locked;

  modport master (
    output chg_req, abort, din_vld, din,
    input  code, busy, stage, cnt, done, err, locked
  );

  modport slave (
    input  chg_req, abort, din_vld, din,
    output code, busy, stage, cnt, done, err, locked
  );
endinterface

// File: rtl/code_writer.sv
// Stored-password owner: verify old code, enter new, confirm, commit.
// Optional consecutive-failure lockout enabled by defining CODE_LOCKOUT_EN.
module code_writer #(
  parameter int unsigned DW = 8
`ifdef CODE_LOCKOUT_EN
  , parameter int unsigned MAX_FAIL    = 3
  , parameter int unsigned LOCK_CYCLES = 16
`endif
) (
  input logic        clk,
  input logic        rst,
  code_writer_if.slave bus
);

  localparam int unsigned ND = DW / 2;
  localparam logic [3:0]  CNT_LAST = 4'(ND - 1);

  typedef enum logic [2:0] {IDLE, VERIFY, NEWC, CONFIRM, LOCK} state_t;

  state_t        state;
  logic [DW-1:0] code;
  logic [DW-1:0] dig_buf;
  logic [DW-1:0] newbuf;
  logic [3:0]    cnt;
  logic [1:0]    stage;
  logic          busy;
  logic          done;
  logic          err;

  logic [DW-1:0] shifted;
  logic          is_last;

  // Phase compare sees the digit being accepted this cycle, so no extra cycle.
  assign shifted = {dig_buf[DW-3:0], bus.din};
  assign is_last = (cnt == CNT_LAST);

`ifdef CODE_LOCKOUT_EN
  localparam int unsigned FW = (MAX_FAIL < 2) ? 1 : $clog2(MAX_FAIL + 1);
  localparam int unsigned TW = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);

  logic [FW-1:0] fails;
  logic [TW-1:0] tmr;
  logic          locked;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      code    <= '1;
      dig_buf <= '0;
      newbuf  <= '0;
      cnt     <= '0;
      stage   <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef CODE_LOCKOUT_EN
      fails   <= '0;
      tmr     <= '0;
      locked  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.chg_req) begin
            state <= VERIFY;
            stage <= 2'd1;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        VERIFY, NEWC, CONFIRM: begin
          if (bus.abort) begin
            state   <= IDLE;
            stage   <= 2'd0;
            busy    <= 1'b0;
            cnt     <= '0;
            dig_buf <= '0;
            newbuf  <= '0;
          end else if (bus.din_vld) begin
            if (!is_last) begin
              dig_buf <= shifted;
              cnt     <= cnt + 4'd1;
            end else begin
              dig_buf <= '0;
              cnt     <= '0;
              case (state)
                VERIFY: begin
                  if (shifted == code) begin
                    state <= NEWC;
                    stage <= 2'd2;
`ifdef CODE_LOCKOUT_EN
                    fails <= '0;
`endif
                  end else begin
                    err   <= 1'b1;
                    state <= IDLE;
                    stage <= 2'd0;
`ifdef CODE_LOCKOUT_EN
                    if (fails == FAIL_LAST) begin
                      state  <= LOCK;
                      locked <= 1'b1;
                      tmr    <= TW'(LOCK_CYCLES - 1);
                      fails  <= '0;
                    end else begin
                      busy  <= 1'b0;
                      fails <= fails + FW'(1);
                    end
`else
                    busy  <= 1'b0;
`endif
                  end
                end
                NEWC: begin
                  newbuf <= shifted;
                  state  <= CONFIRM;
                  stage  <= 2'd3;
                end
                CONFIRM: begin
                  if (shifted == newbuf) begin
                    code <= newbuf;
                    done <= 1'b1;
                  end else begin
                    err  <= 1'b1;
                  end
                  newbuf <= '0;
                  state  <= IDLE;
                  stage  <= 2'd0;
                  busy   <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
`ifdef CODE_LOCKOUT_EN
        // Lockout ignores every input; stage already reads 0, busy stays high.
        LOCK: begin
          if (tmr == '0) begin
            state  <= IDLE;
            busy   <= 1'b0;
            locked <= 1'b0;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
`endif
        default: begin
          state <= IDLE;
          stage <= 2'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.code  = code;
  assign bus.busy  = busy;
  assign bus.stage = stage;
  assign bus.cnt   = cnt;
  assign bus.done  = done;
  assign bus.err   = err;
`ifdef CODE_LOCKOUT_EN
  assign bus.locked = locked;
`else
  assign bus.locked = 1'b0;
`endif

endmodule

// File: tb/tb_code_writer.sv
// Scoreboard bench for code_writer: digit-list reference model, pulse monitor.
module tb_code_writer;
  localparam int unsigned DW          = 8;
  localparam int unsigned ND          = 4;
  localparam int unsigned MAX_FAIL    = 3;
  localparam int unsigned LOCK_CYCLES = 16;

  typedef struct {
    bit         is_done;
    logic [7:0] code;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  code_writer_if #(.DW(DW)) bus ();
  code_writer #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  ev_t exp_q[$];

  int         m_mode;
  int         m_digits[$];
  logic [7:0] m_code;
  logic [7:0] m_new;
  int         m_fails;
  int         m_lock;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] digits_val();
    int v = 0;
    foreach (m_digits[i]) v = v * 4 + m_digits[i];
    return 8'(v);
  endfunction

  task automatic push_ev(input bit is_done);
    ev_t e;
    e.is_done = is_done;
    e.code    = m_code;
    e.cyc     = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_digits.delete();
    m_code  = 8'hFF;
    m_new   = 8'h00;
    m_fails = 0;
    m_lock  = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit chg, input bit ab, input bit vld, input logic [1:0] d);
    logic [7:0] v;
    if (m_lock > 0) begin
      m_lock--;
    end else if (m_mode == 0) begin
      if (chg) begin
        m_mode = 1;
        m_digits.delete();
      end
    end else if (ab) begin
      m_mode = 0;
      m_digits.delete();
    end else if (vld) begin
      m_digits.push_back(int'(d));
      if (m_digits.size() == ND) begin
        v = digits_val();
        m_digits.delete();
        case (m_mode)
          1: begin
            if (v == m_code) begin
              m_mode  = 2;
              m_fails = 0;
            end else begin
              m_mode = 0;
              push_ev(1'b0);
`ifdef CODE_LOCKOUT_EN
              m_fails++;
              if (m_fails == MAX_FAIL) begin
                m_lock  = LOCK_CYCLES;
                m_fails = 0;
              end
`endif
            end
          end
          2: begin
            m_new  = v;
            m_mode = 3;
          end
          default: begin
            m_mode = 0;
            if (v == m_new) begin
              m_code = v;
              push_ev(1'b1);
            end else begin
              push_ev(1'b0);
            end
          end
        endcase
      end
    end
  endtask

  task automatic step(input bit chg, input bit ab, input bit vld, input logic [1:0] d);
    @(negedge clk);
    bus.chg_req = chg;
    bus.abort   = ab;
    bus.din_vld = vld;
    bus.din     = d;
    model_step(chg, ab, vld, d);
    @(posedge clk);
    #1;
    chk("stage",  32'(bus.stage),  (m_lock > 0) ? 32'd0 : 32'(m_mode));
    chk("busy",   32'(bus.busy),   32'((m_mode != 0) || (m_lock > 0)));
    chk("cnt",    32'(bus.cnt),    32'(m_digits.size()));
    chk("code",   32'(bus.code),   32'(m_code));
    chk("locked", 32'(bus.locked), 32'(m_lock > 0));
  endtask

  task automatic send_code(input logic [7:0] v);
    for (int i = 0; i < ND; i++) step(1'b0, 1'b0, 1'b1, v[7 - 2 * i -: 2]);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  // Every done/err pulse must match the next expected event in kind, cycle and code.
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (rst === 1'b0 && (bus.done === 1'b1 || bus.err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%b err=%b expected none (cycle %0d)",
                 bus.done, bus.err, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_done",  32'(bus.done), 32'(e.is_done));
        chk("pulse_err",   32'(bus.err),  32'(!e.is_done));
        chk("pulse_cycle", 32'(cyc),      32'(e.cyc));
        chk("pulse_code",  32'(bus.code), 32'(e.code));
      end
    end
  end

  initial begin
    logic [1:0] d;
    int         r;
    bus.chg_req = 1'b0;
    bus.abort   = 1'b0;
    bus.din_vld = 1'b0;
    bus.din     = 2'd0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_code",  32'(bus.code),  32'hFF);
    chk("rst_stage", 32'(bus.stage), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_err",   32'(bus.err),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_n(2);

    // Full change FF -> 6C
    step(1'b1, 1'b0, 1'b0, 2'd0);
    send_code(8'hFF);
    send_code(8'h6C);
    send_code(8'h6C);
    idle_n(2);

    // Reset in mid-session restores the default code at once
    step(1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b1, 2'd2);
    @(negedge clk);
    bus.din_vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_code",  32'(bus.code),  32'hFF);
    chk("midrst_stage", 32'(bus.stage), 32'd0);
    chk("midrst_busy",  32'(bus.busy),  32'd0);
    chk("midrst_cnt",   32'(bus.cnt),   32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_n(1);

    // Bad verify
    step(1'b1, 1'b0, 1'b0, 2'd0);
    send_code(8'h00);
    idle_n(2);

    // Confirm mismatch
    step(1'b1, 1'b0, 1'b0, 2'd0);
    send_code(8'hFF);
    send_code(8'h6C);
    send_code(8'h6D);
    idle_n(2);

    // Abort in NEWC, final digit coincident with abort, then chg_req with din_vld
    step(1'b1, 1'b0, 1'b0, 2'd0);
    send_code(8'hFF);
    step(1'b0, 1'b0, 1'b1, 2'd1);
    step(1'b0, 1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 1'b1, 2'd3);
    step(1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b1, 1'b1, 2'd3);
    idle_n(1);

    // New code equal to old code commits normally
    step(1'b1, 1'b0, 1'b0, 2'd0);
    send_code(8'hFF);
    send_code(8'hFF);
    send_code(8'hFF);
    idle_n(2);

`ifdef CODE_LOCKOUT_EN
    for (int k = 0; k < MAX_FAIL; k++) begin
      step(1'b1, 1'b0, 1'b0, 2'd0);
      send_code(8'h12);
    end
    for (int k = 0; k < LOCK_CYCLES + 2; k++) step(1'b1, k[0], 1'b1, 2'd3);
    step(1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0);
    send_code(8'hFF);
    send_code(8'h39);
    send_code(8'h39);
    idle_n(2);
`endif

    // Randomized sessions biased toward correct digits so every path is reached
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      d = 2'($urandom_range(0, 3));
      if (m_lock == 0 && (m_mode == 1 || m_mode == 3) && $urandom_range(0, 9) < 8) begin
        if (m_mode == 1) d = 2'(m_code >> (6 - 2 * m_digits.size()));
        else             d = 2'(m_new  >> (6 - 2 * m_digits.size()));
      end
      step(r < 12, r >= 97, (r % 2) == 0 || r < 40, d);
    end
    idle_n(LOCK_CYCLES + 4);

    chk("events_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
